// File: rtl/morse_tx_encoder.sv
// rtl/morse_tx_encoder.sv - Morse symbol FIFO and unit-timed on/off keying engine
//
// Purpose: buffers 2-bit Morse symbol codes and keys them onto serial_out,
// one pattern bit per Morse time unit, with no idle units between symbols.
// Codes: 01 dot (1,0), 10 dash (1,1,1,0), 11 letter gap (0,0),
//        00 word gap (0 x6), but only when MORSE_TX_WORDGAP_EN is defined.
//        Without that macro, 00 is accepted and then dropped.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   sym_in      symbol code to enqueue
//   sym_valid   sym_in is valid this cycle
//   sym_ready   FIFO not full (from the registered full flag)
//   serial_out  keying line, 1 = tone on
//   busy        engine active or FIFO non-empty
//   sym_done    one-cycle pulse when a symbol's last unit completes
//   fifo_level  current FIFO occupancy
//
// Optional feature macro: MORSE_TX_WORDGAP_EN

module morse_tx_encoder #(
  parameter int UNIT_CYCLES = 4,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               sym_in,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     sym_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(UNIT_CYCLES);

  typedef enum logic {IDLE, SEND} state_t;

  // Free-running unit timer. New symbols do not restart it, so every
  // symbol boundary lands on a unit edge.
  logic [CW-1:0] unit_cnt;
  logic          tick;

  assign tick = (unit_cnt == CW'(UNIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_cnt <= '0;
    end else if (tick) begin
      unit_cnt <= '0;
    end else begin
      unit_cnt <= unit_cnt + CW'(1);
    end
  end

  // Symbol FIFO
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          full_q;
  logic          fifo_empty;
  logic          accept;
  logic          push;
  logic          pop;

  assign fifo_empty = (count == '0);
  assign accept     = sym_valid && !full_q;

`ifdef MORSE_TX_WORDGAP_EN
  assign push = accept;
`else
  // A word gap is handshaken normally but never stored.
  assign push = accept && (sym_in != 2'b00);
`endif

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sym_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_next;
      full_q <= (count_next == (AW+1)'(DEPTH));
    end
  end

  assign sym_ready  = !full_q;
  assign fifo_level = count;

  // Pattern of the FIFO head, left-aligned so bit 5 is emitted first.
  // head_len_m1 is the number of bits still to send after the first one.
  logic [5:0] head_pat;
  logic [2:0] head_len_m1;

  always_comb begin
    head_pat    = 6'b000000;
    head_len_m1 = 3'd1;
    case (mem[rd_ptr])
      2'b01: begin head_pat = 6'b100000; head_len_m1 = 3'd1; end
      2'b10: begin head_pat = 6'b111000; head_len_m1 = 3'd3; end
      2'b11: begin head_pat = 6'b000000; head_len_m1 = 3'd1; end
`ifdef MORSE_TX_WORDGAP_EN
      default: begin head_pat = 6'b000000; head_len_m1 = 3'd5; end
`else
      default: begin head_pat = 6'b000000; head_len_m1 = 3'd1; end
`endif
    endcase
  end

  // Keying engine
  state_t     state, state_next;
  logic [5:0] shreg, shreg_next;
  logic [2:0] remaining, remaining_next;
  logic       serial_next;
  logic       done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      remaining  <= '0;
      serial_out <= 1'b0;
      sym_done   <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      remaining  <= remaining_next;
      serial_out <= serial_next;
      sym_done   <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    remaining_next = remaining;
    serial_next    = serial_out;
    done_next      = 1'b0;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        serial_next = 1'b0;
        if (tick && !fifo_empty) begin
          pop            = 1'b1;
          serial_next    = head_pat[5];
          shreg_next     = {head_pat[4:0], 1'b0};
          remaining_next = head_len_m1;
          state_next     = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          if (remaining != 3'd0) begin
            serial_next    = shreg[5];
            shreg_next     = {shreg[4:0], 1'b0};
            remaining_next = remaining - 3'd1;
          end else begin
            // Last unit just finished: chain the next symbol on this edge.
            done_next = 1'b1;
            if (!fifo_empty) begin
              pop            = 1'b1;
              serial_next    = head_pat[5];
              shreg_next     = {head_pat[4:0], 1'b0};
              remaining_next = head_len_m1;
            end else begin
              serial_next = 1'b0;
              state_next  = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_morse_tx_encoder.sv
// tb/tb_morse_tx_encoder.sv - directed self-checking bench for morse_tx_encoder
//
// Purpose: drives symbol sequences and checks keying per clock or per unit
// against hand-computed patterns. Covers the word gap path when
// MORSE_TX_WORDGAP_EN is defined, and the 00-drop path otherwise.

module tb_morse_tx_encoder;

  localparam int UNIT  = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic       serial_out;
  logic       busy;
  logic       sym_done;
  logic [3:0] fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  morse_tx_encoder #(.UNIT_CYCLES(UNIT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .sym_done   (sym_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the negedge following the last reset edge,
  // so the unit counter is 0 and the first tick edge is 4 edges away.
  task automatic do_reset;
    rst       = 1'b1;
    sym_valid = 1'b0;
    sym_in    = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] s);
    sym_in    = s;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  // Optionally waits for the first on-unit, then samples n units.
  // The first sampled unit ends up in the highest bit of the n-bit result.
  task automatic capture(input int n, input bit wait_start,
                         output logic [63:0] ser, output logic [63:0] done,
                         output bit ok);
    ok   = 1'b1;
    ser  = '0;
    done = '0;
    if (wait_start) begin
      ok = 1'b0;
      for (int i = 0; i < 3 * UNIT && !ok; i++) begin
        if (serial_out === 1'b1) ok = 1'b1;
        else @(negedge clk);
      end
    end
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        ser  = {ser[62:0], serial_out};
        done = {done[62:0], sym_done};
        repeat (UNIT) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_serial: got %b expected 0", serial_out); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", sym_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (sym_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", sym_done); end
  endtask

  task automatic test_single_dot;
    int  waited;
    bit  found;
    do_reset();
    push(2'b01);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 3 * UNIT && !found; i++) begin
      if (serial_out === 1'b1) found = 1'b1;
      else begin waited++; @(negedge clk); end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL dot_start: got no output expected start within %0d cycles", 3 * UNIT); end
    // Push edge is reset+1, first tick edge is reset+4.
    n_cmp++; if (waited != 3) begin n_fail++; $display("FAIL dot_latency: got %0d expected 3", waited); end
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (serial_out !== (c < 4)) begin n_fail++; $display("FAIL dot_serial_c%0d: got %b expected %b", c, serial_out, (c < 4)); end
      n_cmp++; if (sym_done !== (c == 8)) begin n_fail++; $display("FAIL dot_done_c%0d: got %b expected %b", c, sym_done, (c == 8)); end
      n_cmp++; if (busy !== (c < 8)) begin n_fail++; $display("FAIL dot_busy_c%0d: got %b expected %b", c, busy, (c < 8)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ser, done;
    bit ok;
    do_reset();
    push(2'b10);
    push(2'b01);
    push(2'b11);
    capture(10, 1'b1, ser, done, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_start: got no output expected start"); end
    n_cmp++; if (ser[9:0] !== 10'b1110100000) begin n_fail++; $display("FAIL b2b_serial: got %b expected 1110100000", ser[9:0]); end
    n_cmp++; if (done[9:0] !== 10'b0000101010) begin n_fail++; $display("FAIL b2b_done: got %b expected 0000101010", done[9:0]); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_full_fifo;
    logic [63:0] ser, done;
    bit ok;
    bit found;
    do_reset();
    push(2'b10);
    found = 1'b0;
    for (int i = 0; i < 3 * UNIT && !found; i++) begin
      if (serial_out === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL full_start: got no output expected dash start"); end
    // The dash holds the engine for 16 cycles, so none of these pops.
    sym_in    = 2'b01;
    sym_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (fifo_level !== 4'((i < 8) ? i + 1 : 8)) begin n_fail++; $display("FAIL full_level_%0d: got %0d expected %0d", i, fifo_level, (i < 8) ? i + 1 : 8); end
      n_cmp++; if (sym_ready !== (i < 7)) begin n_fail++; $display("FAIL full_ready_%0d: got %b expected %b", i, sym_ready, (i < 7)); end
    end
    sym_valid = 1'b0;
    repeat (6) @(negedge clk);
    capture(18, 1'b0, ser, done, ok);
    n_cmp++; if (ser[17:0] !== 18'h2AAA8) begin n_fail++; $display("FAIL full_serial: got %h expected 2aaa8", ser[17:0]); end
    n_cmp++; if (done[17:0] !== 18'h2AAAA) begin n_fail++; $display("FAIL full_done: got %h expected 2aaaa", done[17:0]); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_symbol;
    logic [63:0] ser, done;
    bit ok;
    int highs;
    int dones;
    do_reset();
    push(2'b10);
    push(2'b01);
    capture(2, 1'b1, ser, done, ok);
    n_cmp++; if (ser[1:0] !== 2'b11 || !ok) begin n_fail++; $display("FAIL rst_mid_pre: got %b expected 11", ser[1:0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_serial: got %b expected 0", serial_out); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_mid_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (sym_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", sym_done); end
    highs = 0;
    dones = 0;
    for (int c = 0; c < 8 * UNIT; c++) begin
      if (serial_out === 1'b1) highs++;
      if (sym_done === 1'b1) dones++;
      @(negedge clk);
    end
    n_cmp++; if (highs != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d on-cycles expected 0", highs); end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d pulses expected 0", dones); end
  endtask

`ifdef MORSE_TX_WORDGAP_EN
  task automatic test_word_gap;
    logic [63:0] ser, done;
    bit ok;
    do_reset();
    push(2'b01);
    push(2'b00);
    push(2'b01);
    n_cmp++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL wg_level: got %0d expected 3", fifo_level); end
    capture(12, 1'b1, ser, done, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wg_start: got no output expected start"); end
    n_cmp++; if (ser[11:0] !== 12'b100000001000) begin n_fail++; $display("FAIL wg_serial: got %b expected 100000001000", ser[11:0]); end
    n_cmp++; if (done[11:0] !== 12'b001000001010) begin n_fail++; $display("FAIL wg_done: got %b expected 001000001010", done[11:0]); end
  endtask
`else
  task automatic test_code00_drop;
    logic [63:0] ser, done;
    bit ok;
    do_reset();
    push(2'b00);
    n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL c00_level0: got %0d expected 0", fifo_level); end
    push(2'b01);
    n_cmp++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL c00_level1: got %0d expected 1", fifo_level); end
    capture(8, 1'b1, ser, done, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL c00_start: got no output expected start"); end
    n_cmp++; if (ser[7:0] !== 8'b10000000) begin n_fail++; $display("FAIL c00_serial: got %b expected 10000000", ser[7:0]); end
    n_cmp++; if (done[7:0] !== 8'b00100000) begin n_fail++; $display("FAIL c00_done: got %b expected 00100000", done[7:0]); end
  endtask
`endif

  // Unit-rate reference detector: 1-unit mark = dot, 3-unit mark = dash,
  // third consecutive space unit = letter gap.
  task automatic test_loopback;
    logic [63:0] ser, done;
    bit ok;
    logic [1:0] dec [8];
    logic [1:0] exp_codes [4];
    int ndec;
    int ones;
    int zeros;
    bit started;
    logic b;
    exp_codes[0] = 2'b01;
    exp_codes[1] = 2'b01;
    exp_codes[2] = 2'b10;
    exp_codes[3] = 2'b11;
    do_reset();
    push(2'b01);
    push(2'b01);
    push(2'b10);
    push(2'b11);
    capture(14, 1'b1, ser, done, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL loop_start: got no output expected start"); end
    ndec    = 0;
    ones    = 0;
    zeros   = 0;
    started = 1'b0;
    for (int k = 0; k < 14; k++) begin
      b = ser[13 - k];
      if (b) begin
        started = 1'b1;
        ones++;
        zeros = 0;
      end else if (started) begin
        if (ones != 0 && ndec < 8) begin
          if (ones == 1) begin dec[ndec] = 2'b01; ndec++; end
          else if (ones == 3) begin dec[ndec] = 2'b10; ndec++; end
        end
        ones = 0;
        zeros++;
        if (zeros == 3 && ndec < 8) begin dec[ndec] = 2'b11; ndec++; end
      end
    end
    n_cmp++; if (ndec != 4) begin n_fail++; $display("FAIL loop_count: got %0d expected 4", ndec); end
    for (int i = 0; i < 4; i++) begin
      if (i < ndec) begin
        n_cmp++; if (dec[i] !== exp_codes[i]) begin n_fail++; $display("FAIL loop_code_%0d: got %b expected %b", i, dec[i], exp_codes[i]); end
      end
    end
    n_cmp++; if ($countones(done[13:0]) != 4) begin n_fail++; $display("FAIL loop_done_count: got %0d expected 4", $countones(done[13:0])); end
  endtask

  initial begin
    test_reset();
    test_single_dot();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_symbol();
`ifdef MORSE_TX_WORDGAP_EN
    test_word_gap();
`else
    test_code00_drop();
`endif
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
